// File: rtl/mips_pkg.sv
// Shared opcode constants, FSM state type and access classification helpers
// for the MIPS load/store unit.
package mips_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } lsu_state_t;

  function automatic logic is_load(input logic [5:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: is_load = 1'b1;
      default:                             is_load = 1'b0;
    endcase
  endfunction

  // Unknown opcodes and misaligned halves/words are rejected without a bus cycle.
  function automatic logic access_ok(input logic [5:0] op, input logic [1:0] addr_lo);
    case (op)
      OP_LB, OP_LBU, OP_SB: access_ok = 1'b1;
      OP_LH, OP_LHU, OP_SH: access_ok = ~addr_lo[0];
      OP_LW, OP_SW:         access_ok = (addr_lo == 2'b00);
      default:              access_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lane_align.sv
// Combinational little-endian lane steering: byte enables, store replication
// and load extraction with sign/zero extension.
module lane_align
  import mips_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] read_word,
  output logic [3:0]  byteenable,
  output logic [31:0] write_word,
  output logic [31:0] load_word
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = read_word[7:0];
    case (addr_lo)
      2'd0: sel_byte = read_word[7:0];
      2'd1: sel_byte = read_word[15:8];
      2'd2: sel_byte = read_word[23:16];
      2'd3: sel_byte = read_word[31:24];
      default: sel_byte = read_word[7:0];
    endcase
    sel_half = addr_lo[1] ? read_word[31:16] : read_word[15:0];
  end

  always_comb begin
    byteenable = 4'b0000;
    write_word = store_data;
    load_word  = read_word;
    case (opcode)
      OP_LB, OP_LBU, OP_SB: byteenable = 4'b0001 << addr_lo;
      OP_LH, OP_LHU, OP_SH: byteenable = addr_lo[1] ? 4'b1100 : 4'b0011;
      OP_LW, OP_SW:         byteenable = 4'b1111;
      default:              byteenable = 4'b0000;
    endcase
    case (opcode)
      OP_SB:   write_word = {4{store_data[7:0]}};
      OP_SH:   write_word = {2{store_data[15:0]}};
      default: write_word = store_data;
    endcase
    case (opcode)
      OP_LB:   load_word = {{24{sel_byte[7]}}, sel_byte};
      OP_LBU:  load_word = {24'h000000, sel_byte};
      OP_LH:   load_word = {{16{sel_half[15]}}, sel_half};
      OP_LHU:  load_word = {16'h0000, sel_half};
      default: load_word = read_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MIPS load/store unit: accepts one CPU request at a time, runs a single
// memory command with wait-state support and pulses done on completion.
module load_store_unit
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [5:0]        opcode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic              busy,
  output logic              done,
  output logic [31:0]       load_data,
  output logic              addr_error,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic [31:0]       mem_writedata,
  input  logic [31:0]       mem_readdata,
  input  logic              mem_waitrequest
);

  lsu_state_t        state_q, state_d;
  logic [5:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       sdata_q;
  logic              err_q;
  logic              accept, capture;
  logic [3:0]        lane_be;
  logic [31:0]       lane_wd, lane_ld;

  lane_align u_lane_align (
    .opcode     (op_q),
    .addr_lo    (addr_q[1:0]),
    .store_data (sdata_q),
    .read_word  (mem_readdata),
    .byteenable (lane_be),
    .write_word (lane_wd),
    .load_word  (lane_ld)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= 6'd0;
      addr_q    <= '0;
      sdata_q   <= 32'd0;
      err_q     <= 1'b0;
      load_data <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= opcode;
        addr_q  <= addr;
        sdata_q <= store_data;
        err_q   <= ~access_ok(opcode, addr[1:0]);
      end
      if (capture) load_data <= lane_ld;
    end
  end

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    capture    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    addr_error = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          state_d = access_ok(opcode, addr[1:0]) ? ST_ACCESS : ST_DONE;
        end
      end
      ST_ACCESS: begin
        busy      = 1'b1;
        mem_read  = is_load(op_q);
        mem_write = ~is_load(op_q);
        if (!mem_waitrequest) begin
          capture = is_load(op_q);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        addr_error = err_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_address    = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_byteenable = (state_q == ST_ACCESS) ? lane_be : 4'b0000;
  assign mem_writedata  = lane_wd;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// transactions against an arithmetic reference model of lane steering.
module tb_load_store_unit;

  localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24,
                         LHU = 6'h25, SB = 6'h28, SH = 6'h29, SW = 6'h2B;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] store_data = 32'd0;
  logic        busy, done, addr_error, mem_read, mem_write;
  logic [31:0] load_data, mem_address, mem_writedata;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_readdata = 32'd0;
  logic        mem_waitrequest = 1'b0;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] model_ld = 32'd0;
  logic [5:0]  legal_ops [8] = '{LB, LH, LW, LBU, LHU, SB, SH, SW};

  load_store_unit #(.ADDR_W(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .opcode          (opcode),
    .addr            (addr),
    .store_data      (store_data),
    .busy            (busy),
    .done            (done),
    .load_data       (load_data),
    .addr_error      (addr_error),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byteenable  (mem_byteenable),
    .mem_writedata   (mem_writedata),
    .mem_readdata    (mem_readdata),
    .mem_waitrequest (mem_waitrequest)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit m_is_load(input logic [5:0] op);
    return (op == LB) || (op == LH) || (op == LW) || (op == LBU) || (op == LHU);
  endfunction

  function automatic bit m_legal(input logic [5:0] op, input logic [31:0] a);
    int off = int'(a % 4);
    if (op == LB || op == LBU || op == SB) return 1'b1;
    if (op == LH || op == LHU || op == SH) return (off % 2) == 0;
    if (op == LW || op == SW) return off == 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_be(input logic [5:0] op, input logic [31:0] a);
    int off = int'(a % 4);
    if (op == LB || op == LBU || op == SB) return 4'(1 << off);
    if (op == LH || op == LHU || op == SH) return (off >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wd(input logic [5:0] op, input logic [31:0] sd);
    logic [31:0] b = sd & 32'hFF;
    logic [31:0] h = sd & 32'hFFFF;
    if (op == SB) return b * 32'h01010101;
    if (op == SH) return h * 32'h00010001;
    return sd;
  endfunction

  function automatic logic [31:0] m_ld(input logic [5:0] op, input logic [31:0] a,
                                      input logic [31:0] w);
    int off = int'(a % 4);
    logic [31:0] b = (w >> (8 * off)) & 32'hFF;
    logic [31:0] h = (w >> (8 * (off / 2) * 2)) & 32'hFFFF;
    case (op)
      LB:  return (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
      LBU: return b;
      LH:  return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
      LHU: return h;
      default: return w;
    endcase
  endfunction

  // Issues one request in an IDLE cycle and follows it through done,
  // ending in the IDLE cycle after done.
  task automatic run_txn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sd,
                         input int waits, input logic [31:0] word, input bit fixed);
    logic [31:0] w = word;
    req_valid = 1'b1; opcode = op; addr = a; store_data = sd; mem_waitrequest = 1'b0;
    step();
    req_valid = 1'b0; opcode = 6'($urandom); addr = $urandom; store_data = $urandom;
    if (!m_legal(op, a)) begin
      check("err_done", done, 1'b1);
      check("err_flag", addr_error, 1'b1);
      check("err_rd", mem_read, 1'b0);
      check("err_wr", mem_write, 1'b0);
      check("err_ld", load_data, model_ld);
    end else begin
      for (int i = 0; i <= waits; i++) begin
        mem_waitrequest = (i < waits);
        if (!fixed) w = $urandom;
        mem_readdata = w;
        req_valid = 1'($urandom);
        #1;
        check("acc_rd", mem_read, m_is_load(op));
        check("acc_wr", mem_write, !m_is_load(op));
        check("acc_be", mem_byteenable, m_be(op, a));
        check("acc_addr", mem_address, a & 32'hFFFFFFFC);
        check("acc_busy", busy, 1'b1);
        check("acc_done", done, 1'b0);
        if (!m_is_load(op)) check("acc_wd", mem_writedata, m_wd(op, sd));
        step();
      end
      req_valid = 1'b0;
      mem_waitrequest = 1'b0;
      check("done", done, 1'b1);
      check("done_err", addr_error, 1'b0);
      check("done_strobe", mem_read | mem_write, 1'b0);
      if (m_is_load(op)) begin
        model_ld = m_ld(op, a, w);
        check("load_data", load_data, model_ld);
      end
    end
    step();
    check("post_done", done, 1'b0);
    check("post_busy", busy, 1'b0);
  endtask

  initial begin
    logic [5:0]  op;
    logic [31:0] a;
    step();
    step();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", addr_error, 1'b0);
    check("rst_strobe", {mem_read, mem_write}, 2'b00);
    check("rst_be", mem_byteenable, 4'h0);
    check("rst_ld", load_data, 32'h0);
    reset = 1'b0;
    step();

    run_txn(LW, 32'h10, 32'h0, 0, 32'h8899AABB, 1'b1);
    check("lw_basic", load_data, 32'h8899AABB);
    run_txn(LB, 32'h13, 32'h0, 0, 32'h80112233, 1'b1);
    check("lb_sext", load_data, 32'hFFFFFF80);
    run_txn(LBU, 32'h13, 32'h0, 1, 32'h80112233, 1'b1);
    check("lbu_zext", load_data, 32'h00000080);
    run_txn(SH, 32'h22, 32'h0000BEEF, 3, 32'h0, 1'b0);
    run_txn(LW, 32'h11, 32'h0, 0, 32'h0, 1'b0);
    check("misalign_ld", load_data, 32'h00000080);

    // Reset during the second wait cycle of a store, with a competing request.
    req_valid = 1'b1; opcode = SW; addr = 32'h40; store_data = 32'h12345678;
    step();
    req_valid = 1'b0; mem_waitrequest = 1'b1;
    check("sw_wr", mem_write, 1'b1);
    step();
    reset = 1'b1; req_valid = 1'b1; opcode = LW; addr = 32'h0;
    step();
    reset = 1'b0; req_valid = 1'b0;
    check("rstmid_wr", mem_write, 1'b0);
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_ld", load_data, 32'h0);
    model_ld = 32'h0;
    for (int i = 0; i < 4; i++) begin
      check("rstmid_nodone", {done, mem_read, mem_write}, 3'b000);
      step();
    end
    mem_waitrequest = 1'b0;
    run_txn(LW, 32'h44, 32'h0, 0, 32'hCAFEF00D, 1'b1);
    check("after_rst_lw", load_data, 32'hCAFEF00D);

    for (int t = 0; t < 250; t++) begin
      op = ($urandom_range(0, 9) < 8) ? legal_ops[$urandom_range(0, 7)] : 6'($urandom);
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a = a & 32'hFFFFFFFC;
      run_txn(op, a, $urandom, $urandom_range(0, 3), 32'h0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
